mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
- Parametrised successor to the basic enable/clear counter.
- Adds the following over the basic counter:
  - up/down counting
  - synchronous load
  - programmable modulo limit
  - wrap or saturate mode
  - programmable enable prescaler
  - terminal-count and wrap-event outputs
- Used for baud-rate division, bit/sample counting and timeout timers in the UART datapath.

Parameters:
- WIDTH, 16: width of count, limit and load_value.
- PRESCALE_WIDTH, 8: width of prescale input and of the internal prescale counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; feeds the prescaler.
- clr  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value written on load.
- dir  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  1 = saturate at boundary, 0 = wrap.
- limit  input  WIDTH  modulo top value (inclusive).
- prescale  input  PRESCALE_WIDTH  step occurs every prescale+1 enabled cycles.
- count  output  WIDTH  current count (registered).
- at_bound  output  1  combinational; 1 when count==limit (dir=1) or count==0 (dir=0).
- wrapped  output  1  registered one-cycle pulse after a step that wrapped.
- step  output  1  combinational; 1 in cycles where count advances this edge.

Behaviour:
- Reset (asynchronous, active-high):
  - count=0, prescale counter=0, wrapped=0.
  - Effective immediately, regardless of clk.
  - Reset mid-operation discards all state.
- Priority per edge: reset > clr > load > step > hold.
- clr:
  - count=0, prescale counter=0, wrapped=0 next cycle.
  - Overrides load and en in the same cycle.
- load:
  - count=load_value, prescale counter=0, wrapped=0.
  - load_value above limit is accepted unchanged.
- Prescaler:
  - Counts only when en=1 and neither clr nor load is asserted; en=0 holds it.
  - step=1 when en=1 and prescale counter >= prescale. Prescale counter then returns to 0; otherwise it increments.
  - prescale=0 gives step on every enabled cycle.
  - Lowering prescale below the current prescale counter value causes a step on the next enabled cycle.
- Step, dir=1:
  - count<limit: count+1.
  - count>=limit, sat_mode=0: count=0, wrapped=1 next cycle.
  - count>=limit, sat_mode=1: count=limit, wrapped=0.
- Step, dir=0:
  - count>0: count-1. This applies even when count>limit.
  - count==0, sat_mode=0: count=limit, wrapped=1.
  - count==0, sat_mode=1: count stays 0, wrapped=0.
- wrapped is 0 in every cycle not immediately following a wrapping step.
- dir, sat_mode and limit are sampled each step with no latency. A change takes effect on the next step.
- limit=0:
  - wrap mode: count stays 0 and wrapped pulses on every step.
  - saturate mode: count stays 0 and wrapped stays 0.
- All arithmetic is unsigned, modulo 2^WIDTH. limit = 2^WIDTH-1 behaves as natural rollover.
- Latency: count reflects a step, load or clr one cycle after the qualifying edge.

Decomposition:
- Package mod_counter_pkg holds:
  - count_dir_e enum {DIR_DOWN=0, DIR_UP=1}
  - count_mode_e enum {MODE_WRAP=0, MODE_SAT=1}
  - localparam defaults for WIDTH and PRESCALE_WIDTH
- One sub-module, tick_prescaler:
  - Parameter PRESCALE_WIDTH.
  - Inputs: clk, reset, en, restart, prescale.
  - Output: tick (this is mod_counter's step).
  - Also reusable by the UART baud generator.

Test Plan:
1. Reset and mid-run reset:
   - Stimulus: WIDTH=8, count to 5, then pulse reset between clock edges.
   - Required: count=0 and wrapped=0 immediately; en held 1 resumes from 0.
2. Wrap up:
   - Stimulus: limit=3, dir=1, sat_mode=0, prescale=0, en=1 for 10 cycles.
   - Required: count 0,1,2,3,0,1,2,3,0,1; wrapped pulses the cycle after each 3→0.
3. Saturate down with load above limit:
   - Stimulus: limit=10, load load_value=200, then dir=0, sat_mode=1.
   - Required: count 200,199,... down to 0 and holds 0; at_bound=1 at 0; wrapped never asserts.
4. Prescaler:
   - Stimulus: prescale=2, en=1 continuously.
   - Required: step every 3rd cycle; count increments 1 per 3 cycles.
   - Stimulus: drop en for 4 cycles mid-period.
   - Required: phase is held; step is delayed by exactly 4 cycles.
5. Priority:
   - Stimulus: assert clr, load=1 (load_value=7) and en=1 simultaneously.
   - Required: count=0 next cycle.
   - Stimulus: load=1 with en=1 and a step due.
   - Required: count=7 and prescaler restarted.
6. Direction/limit change and limit=0:
   - Stimulus: at count=5, limit=15, switch dir to 0.
   - Required: next step gives 4.
   - Stimulus: set limit=0, sat_mode=0, dir=1 from count=0.
   - Required: count stays 0 and wrapped pulses every step.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// ============================================================================
// Module      : mod_counter_pkg
// Description : Shared types and default sizes for the modulo counter family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_e;

    localparam int c_WIDTH_DEFAULT          = 16;
    localparam int c_PRESCALE_WIDTH_DEFAULT = 8;

endpackage : mod_counter_pkg

`default_nettype wire

// File: rtl/mod_counter_tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Emits one tick every prescale+1 enabled cycles; restart zeroes
//               the phase. Also used by the UART baud generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import mod_counter_pkg::*;
#(
    parameter int PRESCALE_WIDTH = c_PRESCALE_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      restart,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic                      w_due;

    // >= rather than == so that lowering prescale below the phase still ticks.
    assign w_due = (r_cnt >= prescale);
    assign tick  = en & ~restart & w_due;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_due) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
            end
        end
    end

endmodule : tick_prescaler

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module      : mod_counter
// Description : Up/down modulo counter with load, wrap/saturate modes,
//               enable prescaler, terminal-count and wrap-event outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH          = c_WIDTH_DEFAULT,
    parameter int PRESCALE_WIDTH = c_PRESCALE_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      dir,
    input  logic                      sat_mode,
    input  logic [WIDTH-1:0]          limit,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]          count,
    output logic                      at_bound,
    output logic                      wrapped,
    output logic                      step
);

    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;
    logic [WIDTH-1:0] w_next_count;
    logic             w_wrap;
    logic             w_restart;
    logic             w_up;
    logic             w_sat;

    assign w_up      = (count_dir_e'(dir) == DIR_UP);
    assign w_sat     = (count_mode_e'(sat_mode) == MODE_SAT);
    assign w_restart = clr | load;

    tick_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .restart  (w_restart),
        .prescale (prescale),
        .tick     (step)
    );

    // A count loaded above limit counts up to the boundary immediately, but
    // counts down normally from wherever it is.
    always_comb begin
        w_next_count = r_count;
        w_wrap       = 1'b0;
        if (w_up) begin
            if (r_count >= limit) begin
                if (w_sat) begin
                    w_next_count = limit;
                end else begin
                    w_next_count = '0;
                    w_wrap       = 1'b1;
                end
            end else begin
                w_next_count = r_count + WIDTH'(1);
            end
        end else begin
            if (r_count == '0) begin
                if (w_sat) begin
                    w_next_count = '0;
                end else begin
                    w_next_count = limit;
                    w_wrap       = 1'b1;
                end
            end else begin
                w_next_count = r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_wrapped <= 1'b0;
        end else if (clr) begin
            r_count   <= '0;
            r_wrapped <= 1'b0;
        end else if (load) begin
            r_count   <= load_value;
            r_wrapped <= 1'b0;
        end else if (step) begin
            r_count   <= w_next_count;
            r_wrapped <= w_wrap;
        end else begin
            r_wrapped <= 1'b0;
        end
    end

    assign count    = r_count;
    assign wrapped  = r_wrapped;
    assign at_bound = w_up ? (r_count == limit) : (r_count == '0);

endmodule : mod_counter

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// Module      : tb_mod_counter
// Description : Directed self-checking bench for mod_counter (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

    localparam int WIDTH          = 8;
    localparam int PRESCALE_WIDTH = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      en;
    logic                      clr;
    logic                      load;
    logic [WIDTH-1:0]          load_value;
    logic                      dir;
    logic                      sat_mode;
    logic [WIDTH-1:0]          limit;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [WIDTH-1:0]          count;
    logic                      at_bound;
    logic                      wrapped;
    logic                      step;

    int checks   = 0;
    int failures = 0;

    mod_counter #(
        .WIDTH          (WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .load       (load),
        .load_value (load_value),
        .dir        (dir),
        .sat_mode   (sat_mode),
        .limit      (limit),
        .prescale   (prescale),
        .count      (count),
        .at_bound   (at_bound),
        .wrapped    (wrapped),
        .step       (step)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_value = '0;
        dir = 1'b1; sat_mode = 1'b0; limit = 8'd255; prescale = '0;
        tick();
        checks++;
        if (count !== 8'd0 || wrapped !== 1'b0) begin
            failures++;
            $display("FAIL reset_state count=%0d wrapped=%0b required count=0 wrapped=0", count, wrapped);
        end
        reset = 1'b0;
        en    = 1'b1;
        repeat (5) tick();
        checks++;
        if (count !== 8'd5) begin
            failures++;
            $display("FAIL count_to_5 count=%0d required 5", count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (count !== 8'd0 || wrapped !== 1'b0) begin
            failures++;
            $display("FAIL async_reset count=%0d wrapped=%0b required count=0 wrapped=0", count, wrapped);
        end
        #1 reset = 1'b0;
        tick();
        checks++;
        if (count !== 8'd1) begin
            failures++;
            $display("FAIL resume_after_reset count=%0d required 1", count);
        end
    endtask

    task automatic test_wrap_up();
        logic [WIDTH-1:0] exp_cnt;
        logic             exp_wrap;
        en = 1'b0; limit = 8'd3; dir = 1'b1; sat_mode = 1'b0; prescale = '0;
        do_clear();
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_cnt  = 8'(i % 4);
            exp_wrap = (i == 4) || (i == 8);
            checks++;
            if (count !== exp_cnt || wrapped !== exp_wrap) begin
                failures++;
                $display("FAIL wrap_up[%0d] count=%0d wrapped=%0b required count=%0d wrapped=%0b",
                         i, count, wrapped, exp_cnt, exp_wrap);
            end
            tick();
        end
    endtask

    task automatic test_sat_down_load();
        logic [WIDTH-1:0] exp_cnt;
        en = 1'b0; limit = 8'd10; load = 1'b1; load_value = 8'd200;
        tick();
        load = 1'b0; dir = 1'b0; sat_mode = 1'b1; prescale = '0; en = 1'b1;
        exp_cnt = 8'd200;
        for (int i = 0; i < 205; i++) begin
            checks++;
            if (count !== exp_cnt || wrapped !== 1'b0 || at_bound !== (exp_cnt == 8'd0)) begin
                failures++;
                $display("FAIL sat_down[%0d] count=%0d wrapped=%0b at_bound=%0b required count=%0d wrapped=0 at_bound=%0b",
                         i, count, wrapped, at_bound, exp_cnt, (exp_cnt == 8'd0));
            end
            tick();
            if (exp_cnt != 8'd0) exp_cnt = exp_cnt - 8'd1;
        end
    endtask

    task automatic test_prescaler();
        en = 1'b0; limit = 8'd255; dir = 1'b1; sat_mode = 1'b0; prescale = 8'd2;
        do_clear();
        en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (step !== (k % 3 == 2) || count !== 8'(k / 3)) begin
                failures++;
                $display("FAIL prescale[%0d] step=%0b count=%0d required step=%0b count=%0d",
                         k, step, count, (k % 3 == 2), k / 3);
            end
            tick();
        end
        tick();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (step !== 1'b0 || count !== 8'd3) begin
                failures++;
                $display("FAIL prescale_hold[%0d] step=%0b count=%0d required step=0 count=3", k, step, count);
            end
            tick();
        end
        en = 1'b1;
        checks++;
        if (step !== 1'b0) begin
            failures++;
            $display("FAIL prescale_resume_phase step=%0b required 0", step);
        end
        tick();
        checks++;
        if (step !== 1'b1) begin
            failures++;
            $display("FAIL prescale_delayed_step step=%0b required 1", step);
        end
        tick();
        checks++;
        if (count !== 8'd4) begin
            failures++;
            $display("FAIL prescale_count count=%0d required 4", count);
        end
    endtask

    task automatic test_priority();
        limit = 8'd255; dir = 1'b1; sat_mode = 1'b0; prescale = 8'd2;
        clr = 1'b1; load = 1'b1; load_value = 8'd7; en = 1'b1;
        tick();
        clr = 1'b0; load = 1'b0;
        checks++;
        if (count !== 8'd0) begin
            failures++;
            $display("FAIL clr_over_load count=%0d required 0", count);
        end
        tick();
        tick();
        checks++;
        if (step !== 1'b1) begin
            failures++;
            $display("FAIL step_due step=%0b required 1", step);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 8'd7 || step !== 1'b0) begin
            failures++;
            $display("FAIL load_over_step count=%0d step=%0b required count=7 step=0", count, step);
        end
        tick();
        checks++;
        if (step !== 1'b0 || count !== 8'd7) begin
            failures++;
            $display("FAIL load_restart_phase step=%0b count=%0d required step=0 count=7", step, count);
        end
        tick();
        checks++;
        if (step !== 1'b1) begin
            failures++;
            $display("FAIL load_restart_step step=%0b required 1", step);
        end
        tick();
        checks++;
        if (count !== 8'd8) begin
            failures++;
            $display("FAIL load_then_step count=%0d required 8", count);
        end
    endtask

    task automatic test_dir_limit();
        en = 1'b0; prescale = '0; limit = 8'd15; dir = 1'b1; sat_mode = 1'b0;
        load = 1'b1; load_value = 8'd5;
        tick();
        load = 1'b0;
        dir  = 1'b0;
        en   = 1'b1;
        tick();
        checks++;
        if (count !== 8'd4) begin
            failures++;
            $display("FAIL dir_change count=%0d required 4", count);
        end
        en = 1'b0; limit = 8'd0; dir = 1'b1; sat_mode = 1'b0;
        do_clear();
        checks++;
        if (at_bound !== 1'b1) begin
            failures++;
            $display("FAIL limit0_at_bound at_bound=%0b required 1", at_bound);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count !== 8'd0 || wrapped !== 1'b1) begin
                failures++;
                $display("FAIL limit0_wrap[%0d] count=%0d wrapped=%0b required count=0 wrapped=1", i, count, wrapped);
            end
        end
        sat_mode = 1'b1;
        tick();
        checks++;
        if (count !== 8'd0 || wrapped !== 1'b0) begin
            failures++;
            $display("FAIL limit0_sat count=%0d wrapped=%0b required count=0 wrapped=0", count, wrapped);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down_load();
        test_prescaler();
        test_priority();
        test_dir_limit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mod_counter

`default_nettype wire
